// File: rtl/memory_embedded_burst_ctrl.sv
// Burst controller in front of a single-port BRAM (registered address, unregistered q).
// Each request becomes N_BURST word accesses: writes are flow-controlled, reads stream.
module memory_embedded_burst_ctrl #(
   parameter int BW_DATA = 32,
   parameter int N_BURST = 4,
   parameter int BW_ADDR = 16
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               req_i,
   input  logic               req_rw_i,
   input  logic [BW_ADDR-1:0] req_addr_i,
   output logic               ready_o,
   input  logic [BW_DATA-1:0] wdata_i,
   input  logic               wdata_valid_i,
   output logic               wdata_ready_o,
   output logic [BW_DATA-1:0] rdata_o,
   output logic               rdata_valid_o,
   output logic               done_o,
   output logic               mem_wren_o,
   output logic [BW_ADDR-1:0] mem_addr_o,
   output logic [BW_DATA-1:0] mem_data_o,
   input  logic [BW_DATA-1:0] mem_data_i
);

   localparam int                 LOGN     = $clog2(N_BURST);
   localparam int                 CW       = LOGN + 1;
   localparam logic [BW_ADDR-1:0] OFS_MASK = BW_ADDR'(N_BURST - 1);
   localparam logic [CW-1:0]      LAST     = CW'(N_BURST - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_READ_WAIT,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [BW_ADDR-1:0] base_q;
   logic [CW-1:0]      count_q;
   logic               rw_q;
   logic               rvalid_q;
   logic               wr_phase;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         count_q  <= '0;
         rw_q     <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         // BRAM q lags its address by one cycle, so valid trails the READ state.
         rvalid_q <= (state_q == S_READ);
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  base_q  <= req_addr_i & ~OFS_MASK;
                  count_q <= '0;
                  rw_q    <= req_rw_i;
                  state_q <= req_rw_i ? S_WRITE : S_READ;
               end
            end
            S_WRITE: begin
               if (wdata_valid_i) begin
                  count_q <= count_q + CW'(1);
                  if (count_q == LAST) state_q <= S_DONE;
               end
            end
            S_READ: begin
               count_q <= count_q + CW'(1);
               if (count_q == LAST) state_q <= S_READ_WAIT;
            end
            S_READ_WAIT: state_q <= S_DONE;
            S_DONE:      state_q <= S_IDLE;
            default:     state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_phase      = (state_q == S_WRITE) && rw_q;
   assign ready_o       = (state_q == S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign wdata_ready_o = wr_phase;
   assign mem_wren_o    = wr_phase && wdata_valid_i;
   // Aligned base plus in-line offset: never carries out of the line.
   assign mem_addr_o    = base_q | (BW_ADDR'(count_q) & OFS_MASK);
   assign mem_data_o    = wdata_i;
   assign rdata_o       = mem_data_i;
   assign rdata_valid_o = rvalid_q;

endmodule

// File: doc/memory_embedded_burst_ctrl.md
Name: memory_embedded_burst_ctrl

Overview:
Burst controller directly upstream of the single-port embedded BRAM wrapper in the cache_2stage test system. It takes line-fill and writeback requests from the cache miss handler and turns each one into N_BURST word accesses on the BRAM port. Writes are flow-controlled per word. Reads stream at one word per cycle, and the controller accounts for the BRAM's one-cycle read latency (registered address, unregistered q).

Parameters:
BW_DATA, 32, word width; must match the BRAM data width.
N_BURST, 4, words per line; power of 2, 1..256.
BW_ADDR, 16, word-address width; fixed to the BRAM addr port width.

Ports:
clock_i  in  1  system clock; all state changes on the rising edge.
reset_i  in  1  asynchronous, active-high reset.
req_i  in  1  request strobe; sampled only while ready_o=1.
req_rw_i  in  1  1 = write burst, 0 = read burst; sampled with req_i.
req_addr_i  in  BW_ADDR  line word address; low log2(N_BURST) bits ignored.
ready_o  out  1  controller idle and accepting requests.
wdata_i  in  BW_DATA  write word.
wdata_valid_i  in  1  write word present.
wdata_ready_o  out  1  controller accepts a write word this cycle.
rdata_o  out  BW_DATA  read word; combinational pass-through of mem_data_i.
rdata_valid_o  out  1  rdata_o holds a burst word this cycle.
done_o  out  1  one-cycle pulse marking the end of a burst.
mem_wren_o  out  1  to BRAM wren_i.
mem_addr_o  out  BW_ADDR  to BRAM addr_i.
mem_data_o  out  BW_DATA  to BRAM data_i; equals wdata_i.
mem_data_i  in  BW_DATA  from BRAM data_o.

Behaviour:
- Registers: state, base_q (aligned line address), count_q (log2(N_BURST)+1 bits), rw_q, rvalid_q.
- Reset (async, any state, including mid-burst): state=IDLE; base_q, count_q, rvalid_q = 0.
  - During and after reset: ready_o=1; wdata_ready_o, rdata_valid_o, done_o, mem_wren_o = 0; mem_addr_o=0.
  - An interrupted burst is abandoned; BRAM words already written stay written.
- mem_addr_o = base_q + count_q[log2(N_BURST)-1:0], combinational. base_q is aligned, so the address never carries out of the line. The top line (e.g. 0xFFFC..0xFFFF) needs no wrap handling.
- IDLE: ready_o=1.
  - If req_i=1 at the edge: base_q <= req_addr_i with the low bits cleared; count_q <= 0; rw_q <= req_rw_i.
  - Next state is WRITE if req_rw_i=1, otherwise READ.
- WRITE:
  - wdata_ready_o=1; mem_wren_o = wdata_valid_i.
  - Each cycle with wdata_valid_i=1: count_q increments. Cycles with valid=0 stall with no write.
  - The write of word N_BURST-1 moves to DONE.
- READ:
  - mem_wren_o=0. One address per cycle, no stall: count_q increments every cycle.
  - After N_BURST cycles, moves to READ_WAIT.
- rvalid_q <= (state==READ); rdata_valid_o = rvalid_q.
  - Word k (address base+k) is presented on rdata_o exactly one cycle after its address cycle.
  - The read consumer must always accept; there is no backpressure.
- READ_WAIT: one cycle; the last word is valid on rdata_o. Then DONE.
- DONE: one cycle; done_o=1, ready_o=0. Then IDLE.
- Timing, with request accepted at the end of cycle 0:
  - Read: addresses in cycles 1..N_BURST; data in cycles 2..N_BURST+1; done_o in cycle N_BURST+2; ready_o=1 in cycle N_BURST+3.
  - Write with no stalls: writes in cycles 1..N_BURST; done_o in cycle N_BURST+1.
- Ignored inputs:
  - req_i outside IDLE is ignored and not queued; the requester must re-present it when ready_o=1.
  - wdata_valid_i outside WRITE is ignored.
- Outside WRITE: mem_wren_o=0 and wdata_ready_o=0, always.
- N_BURST=1 case:
  - Read: READ lasts 1 cycle, then READ_WAIT.
  - Write: the single write goes directly to DONE.

Test Plan:
1. Read burst: preload BRAM 0x0040..0x0043 = 0xA0..0xA3; req rw=0, addr 0x0041 -> mem_addr 0x0040..0x0043 in cycles 1..4; rdata_valid_o high cycles 2..5 with 0xA0..0xA3; done_o in cycle 6; ready_o in cycle 7.
2. Write burst with stalls: req rw=1, addr 0x0100; data 0x11, 0x22, 0x33, 0x44 with wdata_valid_i low for 2 cycles after the 2nd word -> exactly 4 mem_wren_o pulses at 0x0100..0x0103; done_o one cycle after 0x44; read-back returns the same data.
3. Top line: req rw=0, addr 0xFFFE -> addresses 0xFFFC..0xFFFF; no wrap to 0x0000.
4. Ignored request: req_i asserted during READ with addr 0x2000 -> no second burst; only one done_o; ready_o returns and the original burst data is unchanged.
5. Reset mid-write: assert reset_i asynchronously after 2 of 4 writes at 0x0200 -> ready_o=1 and mem_wren_o=0 immediately; 0x0200/0x0201 written, 0x0202/0x0203 unchanged; a new read burst then works normally.
6. Back-to-back: write then read of the same line, with req_i asserted in the first ready_o cycle -> read returns the written data; total gap between bursts is 0 idle cycles beyond the single IDLE cycle.
